mmap_copy_engine: RTL and testbench

//  Polled memory-mapped block-copy engine. Watches a control word in the source RAM.

---
 rtl/mmap_copy_engine.sv | 210 +++++++++++++++++++++
 tb/tb_mmap_copy_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmap_copy_engine.sv
// mmap_copy_engine
//   Polled memory-mapped block-copy engine. It keeps reading a control word from the
//   source RAM. When the start bit is seen, it copies LEN payload words to the
//   destination RAM. It then writes a status word and waits for software to clear
//   start before it re-arms.
//
//   Optional feature: define MMAP_CSUM_EN to add an XOR checksum of the copied words.
//   The checksum is written at STAT_ADDR-1 in one extra cycle after the status write.
//
// Ports
//   i_clk    clock, rising edge
//   i_rst    asynchronous reset, active-high
//   o_addr0  source RAM read address
//   i_data   source RAM read data, valid RD_LAT cycles after o_addr0
//   o_addr1  destination RAM write address (holds when o_we=0)
//   o_we     destination write enable
//   o_data   destination write data (holds when o_we=0)
//   o_busy   high from start acceptance until the status (and checksum) write
//   o_done   one-cycle pulse together with the status write
//
// State table
//   POLL     | read the control word, wait RD_LAT settle cycles, then accept start
//   COPY     | issue one payload read per cycle, i = 0..LEN-1
//   DRAIN    | let the in-flight reads come back and get written
//   STATUS   | status word on the write port, o_done pulse
//   CSUM     | checksum word on the write port (MMAP_CSUM_EN only)
//   WAIT_CLR | read the control word until software clears start

module mmap_copy_engine #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 8,
   parameter int RD_LAT    = 1,
   parameter int CTRL_ADDR = 0,
   parameter int DST_BASE  = 0,
   parameter int STAT_ADDR = 1023
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic [ADDR_W-1:0] o_addr0,
   input  logic [DATA_W-1:0] i_data,
   output logic [ADDR_W-1:0] o_addr1,
   output logic              o_we,
   output logic [DATA_W-1:0] o_data,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [2:0] S_POLL     = 3'd0;
   localparam logic [2:0] S_COPY     = 3'd1;
   localparam logic [2:0] S_DRAIN    = 3'd2;
   localparam logic [2:0] S_STATUS   = 3'd3;
   localparam logic [2:0] S_WAIT_CLR = 3'd4;
   localparam logic [2:0] S_CSUM     = 3'd5;

   logic [2:0]       state;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] rd_idx;
   logic [LEN_W-1:0] wr_cnt;
   logic [2:0]       settle_cnt;

   // Valid/index tags that travel alongside the RAM read latency.
   logic             pipe_v   [RD_LAT];
   logic [LEN_W-1:0] pipe_idx [RD_LAT];
   logic             pipe_busy;

`ifdef MMAP_CSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   logic             settled;
   logic [LEN_W-1:0] len_in;
   logic             tap_v;
   logic [LEN_W-1:0] tap_idx;

   assign settled = (settle_cnt == 3'(RD_LAT));
   assign len_in  = i_data[8 +: LEN_W];
   assign tap_v   = pipe_v[RD_LAT-1];
   assign tap_idx = pipe_idx[RD_LAT-1];

   always_comb begin
      pipe_busy = 1'b0;
      for (int k = 0; k < RD_LAT; k++)
         pipe_busy = pipe_busy | pipe_v[k];
   end

   // Payload reads only in COPY; the control word is addressed otherwise, so it is
   // already settled by the time WAIT_CLR starts sampling.
   assign o_addr0 = (state == S_COPY) ? ADDR_W'(CTRL_ADDR + 1 + 32'(rd_idx))
                                      : ADDR_W'(CTRL_ADDR);

   function automatic logic [DATA_W-1:0] status_word(input logic [LEN_W-1:0] cnt);
      logic [DATA_W-1:0] w;
      w             = '0;
      w[8 +: LEN_W] = cnt;
      w[0]          = 1'b1;
      return w;
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= S_POLL;
         len_q      <= '0;
         rd_idx     <= '0;
         wr_cnt     <= '0;
         settle_cnt <= '0;
         o_addr1    <= '0;
         o_we       <= 1'b0;
         o_data     <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         for (int k = 0; k < RD_LAT; k++) begin
            pipe_v[k]   <= 1'b0;
            pipe_idx[k] <= '0;
         end
`ifdef MMAP_CSUM_EN
         csum       <= '0;
`endif
      end else begin
         pipe_v[0]   <= (state == S_COPY);
         pipe_idx[0] <= rd_idx;
         for (int k = 1; k < RD_LAT; k++) begin
            pipe_v[k]   <= pipe_v[k-1];
            pipe_idx[k] <= pipe_idx[k-1];
         end

         o_we   <= 1'b0;
         o_done <= 1'b0;

         // Returned payload word: registered straight onto the write port.
         if (tap_v) begin
            o_we    <= 1'b1;
            o_addr1 <= ADDR_W'(DST_BASE + 32'(tap_idx));
            o_data  <= i_data;
            wr_cnt  <= wr_cnt + LEN_W'(1);
`ifdef MMAP_CSUM_EN
            csum    <= csum ^ i_data;
`endif
         end

         case (state)
            S_POLL: begin
               if (!settled) begin
                  settle_cnt <= settle_cnt + 3'd1;
               end else if (i_data[0]) begin
                  len_q  <= len_in;
                  rd_idx <= '0;
                  wr_cnt <= '0;
                  o_busy <= 1'b1;
`ifdef MMAP_CSUM_EN
                  csum   <= '0;
`endif
                  if (len_in == '0) begin
                     state   <= S_STATUS;
                     o_we    <= 1'b1;
                     o_addr1 <= ADDR_W'(STAT_ADDR);
                     o_data  <= status_word('0);
                     o_done  <= 1'b1;
                  end else begin
                     state <= S_COPY;
                  end
               end
            end
            S_COPY: begin
               rd_idx <= rd_idx + LEN_W'(1);
               if (rd_idx == len_q - LEN_W'(1))
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               // The pipe is empty in the cycle the last data word is on the port,
               // so the status lands exactly one cycle after it.
               if (!pipe_busy) begin
                  state   <= S_STATUS;
                  o_we    <= 1'b1;
                  o_addr1 <= ADDR_W'(STAT_ADDR);
                  o_data  <= status_word(wr_cnt);
                  o_done  <= 1'b1;
               end
            end
            S_STATUS: begin
               settle_cnt <= '0;
`ifdef MMAP_CSUM_EN
               state      <= S_CSUM;
               o_we       <= 1'b1;
               o_addr1    <= ADDR_W'(STAT_ADDR - 1);
               o_data     <= csum;
`else
               state      <= S_WAIT_CLR;
               o_busy     <= 1'b0;
`endif
            end
            S_CSUM: begin
               state      <= S_WAIT_CLR;
               o_busy     <= 1'b0;
               settle_cnt <= '0;
            end
            S_WAIT_CLR: begin
               if (!settled) begin
                  settle_cnt <= settle_cnt + 3'd1;
               end else if (!i_data[0]) begin
                  state      <= S_POLL;
                  settle_cnt <= '0;
               end
            end
            default: state <= S_POLL;
         endcase
      end
   end

endmodule

// File: tb/tb_mmap_copy_engine.sv
// Testbench for mmap_copy_engine: one instance with RD_LAT=1 (a) and one with RD_LAT=3 (b),
// each with a behavioural source RAM. Expected destination writes are queued when a job
// is started and are popped as the DUT writes.
module tb_mmap_copy_engine;

`ifdef MMAP_CSUM_EN
   localparam int CSUM_X = 1;
`else
   localparam int CSUM_X = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [9:0]  addr0_a, addr1_a, addr0_b, addr1_b;
   logic [31:0] rd_a, rd_b, wdata_a, wdata_b, b_s1, b_s2;
   logic        we_a, we_b, busy_a, busy_b, done_a, done_b;

   logic [31:0] mem_a [1024];
   logic [31:0] mem_b [1024];

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t q_a[$];
   wr_t q_b[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int nwr      [2];
   int first_wr [2];
   int last_wr  [2];
   int n_done   [2];
   int done_cyc [2];
   int busy_cyc [2];
   int csum_cyc [2];
   int t_set;

   mmap_copy_engine #(.RD_LAT(1)) dut_a (
      .i_clk(clk), .i_rst(rst), .o_addr0(addr0_a), .i_data(rd_a), .o_addr1(addr1_a),
      .o_we(we_a), .o_data(wdata_a), .o_busy(busy_a), .o_done(done_a));

   mmap_copy_engine #(.RD_LAT(3)) dut_b (
      .i_clk(clk), .i_rst(rst), .o_addr0(addr0_b), .i_data(rd_b), .o_addr1(addr1_b),
      .o_we(we_b), .o_data(wdata_b), .o_busy(busy_b), .o_done(done_b));

   always @(posedge clk) rd_a <= mem_a[addr0_a];
   always @(posedge clk) begin
      b_s1 <= mem_b[addr0_b];
      b_s2 <= b_s1;
      rd_b <= b_s2;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic observe(input int sel, input logic we, input logic [9:0] addr,
                          input logic [31:0] data, input logic done, input logic busy);
      wr_t e;
      int  qs;
      qs = (sel == 1) ? q_b.size() : q_a.size();
      if (we) begin
         check((sel == 1) ? "b_write_expected" : "a_write_expected", 64'(qs != 0), 64'd1);
         if (qs != 0) begin
            if (sel == 1) e = q_b.pop_front();
            else          e = q_a.pop_front();
            check((sel == 1) ? "b_write_addr" : "a_write_addr", 64'(addr), 64'(e.addr));
            check((sel == 1) ? "b_write_data" : "a_write_data", 64'(data), 64'(e.data));
         end
         if (addr < 10'd1022) begin
            nwr[sel]++;
            if (first_wr[sel] < 0) first_wr[sel] = cyc;
            last_wr[sel] = cyc;
         end
         if (addr == 10'd1022) csum_cyc[sel] = cyc;
      end
      if (done) begin
         n_done[sel]++;
         done_cyc[sel] = cyc;
         check((sel == 1) ? "b_done_with_status" : "a_done_with_status",
               64'({we, addr}), 64'({1'b1, 10'd1023}));
      end
      if (busy) busy_cyc[sel]++;
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      observe(0, we_a, addr1_a, wdata_a, done_a, busy_a);
      observe(1, we_b, addr1_b, wdata_b, done_b, busy_b);
   endtask

   task automatic clear_stats(input int sel);
      nwr[sel]      = 0;
      first_wr[sel] = -1;
      last_wr[sel]  = -1;
      n_done[sel]   = 0;
      done_cyc[sel] = -1;
      busy_cyc[sel] = 0;
      csum_cyc[sel] = -1;
   endtask

   // Expected writes for a job of len words, taken from the bench's own source memory.
   task automatic push_job(input int sel, input int len);
      wr_t         e;
      logic [31:0] x;
      x = '0;
      for (int i = 0; i < len; i++) begin
         e.addr = 10'(i);
         e.data = (sel == 1) ? mem_b[i+1] : mem_a[i+1];
         x      = x ^ e.data;
         if (sel == 1) q_b.push_back(e); else q_a.push_back(e);
      end
      e.addr = 10'd1023;
      e.data = {16'h0, 8'(len), 8'h01};
      if (sel == 1) q_b.push_back(e); else q_a.push_back(e);
`ifdef MMAP_CSUM_EN
      e.addr = 10'd1022;
      e.data = x;
      if (sel == 1) q_b.push_back(e); else q_a.push_back(e);
`endif
   endtask

   task automatic wait_done(input int sel, input int budget, input string tag);
      int base;
      base = n_done[sel];
      for (int i = 0; i < budget && n_done[sel] == base; i++) tick();
      check(tag, 64'(n_done[sel] != base), 64'd1);
   endtask

   task automatic release_start_a();
      mem_a[0] = 32'h0;
      repeat (6) tick();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 32'h0;
         mem_b[i] = 32'h0;
      end
      clear_stats(0);
      clear_stats(1);

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check("reset_outputs_a", 64'({addr0_a, addr1_a, we_a, wdata_a, busy_a, done_a}), 64'd0);
      check("reset_outputs_b", 64'({addr0_b, addr1_b, we_b, wdata_b, busy_b, done_b}), 64'd0);
      rst = 1'b0;
      repeat (5) tick();

      // 1: LEN=4 copy on RD_LAT=1
      mem_a[1] = 32'h11; mem_a[2] = 32'h22; mem_a[3] = 32'h33; mem_a[4] = 32'h44;
      clear_stats(0);
      push_job(0, 4);
      mem_a[0] = 32'h0000_0401;
      t_set = cyc;
      wait_done(0, 40, "t1_done");
      check("t1_first_write_latency", 64'(first_wr[0] - t_set), 64'd4);
      check("t1_word_count", 64'(nwr[0]), 64'd4);
      check("t1_back_to_back", 64'(last_wr[0] - first_wr[0]), 64'd3);
      check("t1_status_after_last", 64'(done_cyc[0] - last_wr[0]), 64'd1);
      tick();
      check("t1_busy_after_status", 64'(busy_a), 64'(CSUM_X));
      tick();
      check("t1_busy_low", 64'(busy_a), 64'd0);
      check("t1_single_done", 64'(n_done[0]), 64'd1);

      // 2: LEN=0
      release_start_a();
      clear_stats(0);
      push_job(0, 0);
      mem_a[0] = 32'h0000_0001;
      wait_done(0, 20, "t2_done");
      repeat (3) tick();
      check("t2_no_data_writes", 64'(nwr[0]), 64'd0);
      check("t2_busy_cycles", 64'(busy_cyc[0]), 64'(1 + CSUM_X));

      // 3: start held high, then re-armed
      release_start_a();
      mem_a[1] = 32'hCAFE_0001; mem_a[2] = 32'hCAFE_0002;
      clear_stats(0);
      push_job(0, 2);
      mem_a[0] = 32'h0000_0201;
      wait_done(0, 30, "t3_first_done");
      repeat (50) tick();
      check("t3_one_copy_while_held", 64'(n_done[0]), 64'd1);
      check("t3_no_extra_writes", 64'(nwr[0]), 64'd2);
      release_start_a();
      push_job(0, 2);
      mem_a[0] = 32'h0000_0201;
      wait_done(0, 30, "t3_second_done");
      check("t3_second_copy", 64'(n_done[0]), 64'd2);
      check("t3_total_words", 64'(nwr[0]), 64'd4);

      // 5: reset mid-copy, restart with start still set
      release_start_a();
      for (int i = 1; i <= 4; i++) mem_a[i] = 32'hA0A0_0000 + 32'(i);
      clear_stats(0);
      push_job(0, 4);
      mem_a[0] = 32'h0000_0401;
      for (int i = 0; i < 40 && nwr[0] < 2; i++) tick();
      check("t5_reached_two_writes", 64'(nwr[0]), 64'd2);
      rst = 1'b1;
      #1;
      check("t5_outputs_in_reset", 64'({addr0_a, addr1_a, we_a, wdata_a, busy_a, done_a}), 64'd0);
      q_a.delete();
      repeat (3) tick();
      check("t5_no_status_on_abort", 64'(n_done[0]), 64'd0);
      check("t5_no_write_in_reset", 64'(nwr[0]), 64'd2);
      rst = 1'b0;
      clear_stats(0);
      push_job(0, 4);
      wait_done(0, 40, "t5_restart_done");
      check("t5_restart_words", 64'(nwr[0]), 64'd4);
      repeat (3) tick();

`ifdef MMAP_CSUM_EN
      // 6: checksum write
      release_start_a();
      mem_a[1] = 32'hF0F0_0000; mem_a[2] = 32'h0F0F_FFFF;
      clear_stats(0);
      push_job(0, 2);
      mem_a[0] = 32'h0000_0201;
      wait_done(0, 30, "t6_done");
      tick();
      check("t6_csum_after_status", 64'(csum_cyc[0] - done_cyc[0]), 64'd1);
      check("t6_busy_during_csum", 64'(busy_a), 64'd1);
      tick();
      check("t6_busy_low_after_csum", 64'(busy_a), 64'd0);
`endif

      // 4: RD_LAT=3, LEN=255
      for (int i = 1; i <= 255; i++) mem_b[i] = 32'(i) * 32'h0101_0101;
      clear_stats(1);
      push_job(1, 255);
      mem_b[0] = 32'h0000_FF01;
      t_set = cyc;
      wait_done(1, 400, "t4_done");
      check("t4_first_write_latency", 64'(first_wr[1] - t_set), 64'd8);
      check("t4_word_count", 64'(nwr[1]), 64'd255);
      check("t4_back_to_back", 64'(last_wr[1] - first_wr[1]), 64'd254);
      check("t4_status_after_last", 64'(done_cyc[1] - last_wr[1]), 64'd1);
      repeat (4) tick();

      check("queue_a_drained", 64'(q_a.size()), 64'd0);
      check("queue_b_drained", 64'(q_b.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
